imm_gen_stage: RTL and testbench

//   Registered, handshaked immediate-decode stage for RV32I/RV64I. Sits between fetch and decode.

---
 rtl/imm_gen_stage_if.sv | 29 ++
 rtl/imm_gen_stage.sv | 166 ++++++++++++++++
 tb/tb_imm_gen_stage.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_stage_if.sv
// Handshake bundle between fetch and the immediate-decode stage.
// The slave side is the stage itself; the master side is the fetch/decode environment.
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_instr;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_imm;
  logic [2:0]       o_fmt;
  logic             o_illegal;
  logic [31:0]      o_instr;
  logic [TAG_W-1:0] o_tag;
  logic [15:0]      o_illegal_cnt;

  modport slave (
    input  i_valid, i_instr, i_tag, i_ready,
    output o_ready, o_valid, o_imm, o_fmt, o_illegal, o_instr, o_tag, o_illegal_cnt
  );

  modport master (
    output i_valid, i_instr, i_tag, i_ready,
    input  o_ready, o_valid, o_imm, o_fmt, o_illegal, o_instr, o_tag, o_illegal_cnt
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Registered RV32I/RV64I immediate-decode stage with optional 2-entry skid buffer.
//   state    | meaning
//   EMPTY    | no word held, o_valid low
//   ONE      | output register holds a word
//   FULL2    | output and skid registers both hold words, o_ready low
module imm_gen_stage #(
  parameter int XLEN   = 32,
  parameter int EN_CSR = 1,
  parameter int SKID   = 1,
  parameter int TAG_W  = 32
) (
  input logic          i_clk,
  input logic          i_rst_n,
  imm_gen_stage_if.slave bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL2 = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
  } rec_t;

  state_t          state_q, state_d;
  rec_t            out_q, skid_q, dec_rec;
  logic [31:0]     ins;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            xfer_in, xfer_out;
  logic            ld_out_in, ld_out_skid, ld_skid;
  logic [15:0]     ill_cnt_q;

  assign ins = bus.i_instr;

  // Opcodes whose low two bits are not 2'b11 never match, so they fall to ILL.
  always_comb begin
    dec_fmt = FMT_ILL;
    case (ins[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_MISC: dec_fmt = FMT_I;
      OPC_STORE:   dec_fmt = FMT_S;
      OPC_BRANCH:  dec_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: dec_fmt = FMT_U;
      OPC_JAL:     dec_fmt = FMT_J;
      OPC_OP:      dec_fmt = FMT_R;
      OPC_SYSTEM:  dec_fmt = (EN_CSR != 0) ? FMT_Z : FMT_I;
      OPC_OPIMM32: dec_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
      OPC_OP32:    dec_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
      default:     dec_fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    dec_imm = '0;
    case (dec_fmt)
      FMT_I: dec_imm = {{(XLEN-11){ins[31]}}, ins[30:20]};
      FMT_S: dec_imm = {{(XLEN-11){ins[31]}}, ins[30:25], ins[11:7]};
      FMT_B: dec_imm = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U: dec_imm = {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0};
      FMT_J: dec_imm = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_Z: dec_imm = {{(XLEN-5){1'b0}}, ins[19:15]};
      default: dec_imm = '0;
    endcase
  end

  always_comb begin
    dec_rec.imm   = dec_imm;
    dec_rec.fmt   = dec_fmt;
    dec_rec.instr = ins;
    dec_rec.tag   = bus.i_tag;
  end

  // Without the skid register FULL2 is unreachable: ready then requires i_ready.
  assign bus.o_valid = (state_q != ST_EMPTY);
  assign bus.o_ready = (SKID != 0) ? (state_q != ST_FULL2)
                                   : ((state_q == ST_EMPTY) || bus.i_ready);
  assign xfer_in  = bus.i_valid & bus.o_ready;
  assign xfer_out = bus.o_valid & bus.i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ld_out_in   = 1'b0;
    ld_out_skid = 1'b0;
    ld_skid     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (xfer_in) begin
          state_d   = ST_ONE;
          ld_out_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (xfer_in && xfer_out) begin
          ld_out_in = 1'b1;
        end else if (xfer_in) begin
          state_d = ST_FULL2;
          ld_skid = 1'b1;
        end else if (xfer_out) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL2: begin
        if (xfer_out) begin
          state_d     = ST_ONE;
          ld_out_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q     <= '0;
      skid_q    <= '0;
      ill_cnt_q <= '0;
    end else begin
      if (ld_out_in)        out_q <= dec_rec;
      else if (ld_out_skid) out_q <= skid_q;
      if (ld_skid)          skid_q <= dec_rec;
      if (xfer_in && (dec_fmt == FMT_ILL) && (ill_cnt_q != 16'hFFFF))
        ill_cnt_q <= ill_cnt_q + 16'd1;
    end
  end

  assign bus.o_imm         = out_q.imm;
  assign bus.o_fmt         = out_q.fmt;
  assign bus.o_illegal     = (out_q.fmt == FMT_ILL);
  assign bus.o_instr       = out_q.instr;
  assign bus.o_tag         = out_q.tag;
  assign bus.o_illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: dut_a is XLEN=32/EN_CSR=1/SKID=1, dut_b is XLEN=64/EN_CSR=0/SKID=0,
// both fed from the same stimulus and each checked against its own scoreboard.
module tb_imm_gen_stage;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [31:0] instr;
    logic [31:0] tag;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm_a;
    logic [2:0]  fmt_a;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, ready;
  logic [31:0] instr, tag;

  int   nvec = 0;
  int   nbad = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t held[2];
  bit   hold_v[2];
  int   mcnt[2];

  vec_t        tbl[19];
  logic [31:0] bp[4];
  logic [6:0]  ops[16];

  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) ifa ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) ifb ();

  assign ifa.i_valid = valid;
  assign ifa.i_ready = ready;
  assign ifa.i_instr = instr;
  assign ifa.i_tag   = tag;
  assign ifb.i_valid = valid;
  assign ifb.i_ready = ready;
  assign ifb.i_instr = instr;
  assign ifb.i_tag   = tag;

  imm_gen_stage #(.XLEN(32), .EN_CSR(1), .SKID(1), .TAG_W(32)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
  imm_gen_stage #(.XLEN(64), .EN_CSR(0), .SKID(0), .TAG_W(32)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [131:0] act, input logic [131:0] req);
    nvec++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Reference decode: format from the opcode map, value as a signed integer built from field weights.
  function automatic exp_t ref_dec(input logic [31:0] w, input bit is64, input bit csr,
                                   input logic [31:0] t);
    int          f;
    longint      v;
    logic [63:0] vv;
    exp_t        r;
    f = 7;
    v = 0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F: f = 1;
      7'h23: f = 2;
      7'h63: f = 3;
      7'h37, 7'h17: f = 4;
      7'h6F: f = 5;
      7'h33: f = 0;
      7'h73: f = csr ? 6 : 1;
      7'h1B: f = is64 ? 1 : 7;
      7'h3B: f = is64 ? 0 : 7;
      default: f = 7;
    endcase
    case (f)
      1: v = longint'($signed(w)) >>> 20;
      2: v = (longint'($signed(w)) >>> 25) * 32 + longint'(w[11:7]);
      3: v = (w[31] ? -64'sd4096 : 64'sd0) + longint'(w[7]) * 2048
             + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
      4: v = longint'($signed(w & 32'hFFFFF000));
      5: v = (w[31] ? -64'sd1048576 : 64'sd0) + longint'(w[19:12]) * 4096
             + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
      6: v = longint'(w[19:15]);
      default: v = 0;
    endcase
    vv = v;
    if (!is64) vv[63:32] = '0;
    r.fmt   = 3'(f);
    r.imm   = vv;
    r.instr = w;
    r.tag   = t;
    return r;
  endfunction

  task automatic mon(input int id, input logic ov, input logic orr, input logic [63:0] imm,
                     input logic [2:0] fmt, input logic ill, input logic [31:0] oi,
                     input logic [31:0] ot, input logic [15:0] cnt);
    exp_t  cur, e;
    string nm;
    nm = (id == 0) ? "a" : "b";
    cur.fmt = fmt; cur.imm = imm; cur.instr = oi; cur.tag = ot;
    if (hold_v[id]) begin
      chk({nm, "_hold_valid"}, 132'(ov), 132'(1'b1));
      chk({nm, "_hold_data"}, 132'(cur), 132'(held[id]));
    end
    chk({nm, "_illegal_cnt"}, 132'(cnt), 132'(mcnt[id]));
    if (ov && ready) begin
      nvec++;
      if ((id == 0 ? qa.size() : qb.size()) == 0) begin
        nbad++;
        $display("FAIL %s_spurious_out: actual instr %0h required no output", nm, oi);
      end else begin
        e = (id == 0) ? qa.pop_front() : qb.pop_front();
        chk({nm, "_out_word"}, 132'(cur), 132'(e));
        chk({nm, "_out_illegal"}, 132'(ill), 132'(e.fmt == 3'd7));
      end
    end
    if (valid && orr) begin
      e = ref_dec(instr, id == 1, id == 0, tag);
      if (id == 0) qa.push_back(e);
      else         qb.push_back(e);
      if (e.fmt == 3'd7 && mcnt[id] < 65535) mcnt[id]++;
    end
    hold_v[id] = ov && !ready;
    held[id]   = cur;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      hold_v[0] = 1'b0; hold_v[1] = 1'b0;
      mcnt[0] = 0; mcnt[1] = 0;
    end else begin
      mon(0, ifa.o_valid, ifa.o_ready, {32'b0, ifa.o_imm}, ifa.o_fmt, ifa.o_illegal,
          ifa.o_instr, ifa.o_tag, ifa.o_illegal_cnt);
      mon(1, ifb.o_valid, ifb.o_ready, ifb.o_imm, ifb.o_fmt, ifb.o_illegal,
          ifb.o_instr, ifb.o_tag, ifb.o_illegal_cnt);
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 15)];
    return w;
  endfunction

  initial begin
    int k, acc, g;
    bit took;

    tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1};
    tbl[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3};
    tbl[2]  = '{32'h0000006F, 32'h00000000, 3'd5, 64'h0, 3'd5};
    tbl[3]  = '{32'h800000B7, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4};
    tbl[4]  = '{32'h300FD073, 32'h0000001F, 3'd6, 64'h300, 3'd1};
    tbl[5]  = '{32'h00000000, 32'h00000000, 3'd7, 64'h0, 3'd7};
    tbl[6]  = '{32'h0000007F, 32'h00000000, 3'd7, 64'h0, 3'd7};
    tbl[7]  = '{32'hFFF0009B, 32'h00000000, 3'd7, 64'hFFFFFFFFFFFFFFFF, 3'd1};
    tbl[8]  = '{32'h40B5053B, 32'h00000000, 3'd7, 64'h0, 3'd0};
    tbl[9]  = '{32'h00B50533, 32'h00000000, 3'd0, 64'h0, 3'd0};
    tbl[10] = '{32'hFE112C23, 32'hFFFFFFF8, 3'd2, 64'hFFFFFFFFFFFFFFF8, 3'd2};
    tbl[11] = '{32'h12345017, 32'h12345000, 3'd4, 64'h12345000, 3'd4};
    tbl[12] = '{32'hFFF00091, 32'h00000000, 3'd7, 64'h0, 3'd7};
    tbl[13] = '{32'h7FFFF06F, 32'h000FFFFE, 3'd5, 64'h000FFFFE, 3'd5};
    tbl[14] = '{32'h00008067, 32'h00000000, 3'd1, 64'h0, 3'd1};
    tbl[15] = '{32'h0FF0000F, 32'h000000FF, 3'd1, 64'hFF, 3'd1};
    tbl[16] = '{32'h00000073, 32'h00000000, 3'd6, 64'h0, 3'd1};
    tbl[17] = '{32'h00208463, 32'h00000008, 3'd3, 64'h8, 3'd3};
    tbl[18] = '{32'hFF9FF0EF, 32'hFFFFFFF8, 3'd5, 64'hFFFFFFFFFFFFFFF8, 3'd5};
    bp[0] = 32'h00100093; bp[1] = 32'h00200113; bp[2] = 32'h00300193; bp[3] = 32'h00400213;
    ops[0] = 7'h03; ops[1] = 7'h13; ops[2] = 7'h67; ops[3] = 7'h0F;
    ops[4] = 7'h1B; ops[5] = 7'h23; ops[6] = 7'h63; ops[7] = 7'h37;
    ops[8] = 7'h17; ops[9] = 7'h6F; ops[10] = 7'h33; ops[11] = 7'h3B;
    ops[12] = 7'h73; ops[13] = 7'h7F; ops[14] = 7'h00; ops[15] = 7'h5B;

    rst_n = 1'b0; valid = 1'b0; ready = 1'b1; instr = '0; tag = '0;
    #2;
    chk("rst_a_valid", 132'(ifa.o_valid), 132'(1'b0));
    chk("rst_a_ready", 132'(ifa.o_ready), 132'(1'b1));
    chk("rst_a_data", 132'({ifa.o_imm, ifa.o_fmt, ifa.o_illegal, ifa.o_instr, ifa.o_tag}), 132'(0));
    chk("rst_a_cnt", 132'(ifa.o_illegal_cnt), 132'(0));
    chk("rst_b_valid", 132'(ifb.o_valid), 132'(1'b0));
    chk("rst_b_ready", 132'(ifb.o_ready), 132'(1'b1));
    chk("rst_b_imm", 132'(ifb.o_imm), 132'(0));
    chk("rst_b_rest", 132'({ifb.o_fmt, ifb.o_illegal, ifb.o_instr, ifb.o_tag, ifb.o_illegal_cnt}), 132'(0));
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      valid = 1'b1; instr = tbl[i].instr; tag = 32'(i);
      @(posedge clk); #1 valid = 1'b0;
      @(negedge clk);
      chk($sformatf("tbl%0d_a_valid", i), 132'(ifa.o_valid), 132'(1'b1));
      chk($sformatf("tbl%0d_a_imm", i), 132'(ifa.o_imm), 132'(tbl[i].imm_a));
      chk($sformatf("tbl%0d_a_fmt", i), 132'(ifa.o_fmt), 132'(tbl[i].fmt_a));
      chk($sformatf("tbl%0d_a_ill", i), 132'(ifa.o_illegal), 132'(tbl[i].fmt_a == 3'd7));
      chk($sformatf("tbl%0d_a_tag", i), 132'(ifa.o_tag), 132'(i));
      chk($sformatf("tbl%0d_b_imm", i), 132'(ifb.o_imm), 132'(tbl[i].imm_b));
      chk($sformatf("tbl%0d_b_fmt", i), 132'(ifb.o_fmt), 132'(tbl[i].fmt_b));
      chk($sformatf("tbl%0d_b_instr", i), 132'(ifb.o_instr), 132'(tbl[i].instr));
      @(posedge clk); #1;
    end

    // Backpressure on the skid-buffered instance.
    valid = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 ready = 1'b0;
    k = 0; acc = 0;
    valid = 1'b1; instr = bp[0]; tag = 32'd100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      took = ifa.o_ready;
      if (took) acc++;
      @(posedge clk); #1;
      if (took) begin k++; instr = bp[k]; tag = 32'(100 + k); end
    end
    @(negedge clk);
    chk("bp_accepts", 132'(acc), 132'(2));
    chk("bp_ready_low", 132'(ifa.o_ready), 132'(1'b0));
    chk("bp_held_valid", 132'(ifa.o_valid), 132'(1'b1));
    chk("bp_held_instr", 132'(ifa.o_instr), 132'(bp[0]));
    @(posedge clk); #1 ready = 1'b1;
    g = 0;
    while (k < 4 && g < 20) begin
      @(negedge clk);
      took = ifa.o_ready;
      @(posedge clk); #1;
      if (took) begin
        k++;
        if (k < 4) begin instr = bp[k]; tag = 32'(100 + k); end
      end
      g++;
    end
    valid = 1'b0;
    chk("bp_all_accepted", 132'(k), 132'(4));
    g = 0;
    while (qa.size() != 0 && g < 20) begin @(posedge clk); g++; end
    #1 chk("bp_drained", 132'(qa.size()), 132'(0));

    repeat (3000) begin
      @(posedge clk); #1;
      valid = 1'($urandom_range(0, 1));
      ready = ($urandom_range(0, 3) != 0);
      instr = rand_instr();
      tag   = $urandom;
    end

    // Illegal counter: two words, then saturation.
    @(posedge clk); #1 valid = 1'b0; ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 valid = 1'b1; instr = 32'h00000000;
    @(posedge clk); #1 instr = 32'h0000007F;
    @(posedge clk); #1 valid = 1'b0;
    @(negedge clk);
    chk("cnt2_a", 132'(ifa.o_illegal_cnt), 132'(2));
    chk("cnt2_b", 132'(ifb.o_illegal_cnt), 132'(2));
    chk("ill_a_flag", 132'(ifa.o_illegal), 132'(1'b1));
    chk("ill_a_fmt", 132'(ifa.o_fmt), 132'(7));
    @(posedge clk); #1 valid = 1'b1; instr = 32'h00000000;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("cnt_sat_a", 132'(ifa.o_illegal_cnt), 132'(16'hFFFF));
    chk("cnt_sat_b", 132'(ifb.o_illegal_cnt), 132'(16'hFFFF));

    // Reset in the middle of a stream.
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_a_valid", 132'(ifa.o_valid), 132'(1'b0));
    chk("midrst_a_cnt", 132'(ifa.o_illegal_cnt), 132'(0));
    chk("midrst_a_ready", 132'(ifa.o_ready), 132'(1'b1));
    chk("midrst_b_valid", 132'(ifb.o_valid), 132'(1'b0));
    chk("midrst_b_cnt", 132'(ifb.o_illegal_cnt), 132'(0));
    @(posedge clk); #1;
    chk("midrst_edge_valid", 132'(ifa.o_valid), 132'(1'b0));
    @(negedge clk); #1 rst_n = 1'b1; valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
